sigmoid_stream_driver: RTL and testbench

- Initiator side of the handshake to the iterative FP16 Sigmoid core. The core is started by a one-cycle reset pulse and signals completion with Finished.
- Accepts FP16 operands on a valid/ready input stream and sequences each one through the core.
- Captures the core result and presents it on a valid/ready output stream for the layer post-processing path.
- Short-circuits saturated and NaN operands, and guards against a hung core with a timeout.

---
 rtl/sigmoid_stream_driver.sv | 130 +++++++++++++
 tb/tb_sigmoid_stream_driver.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_stream_driver.sv
// Stream front end for the iterative FP16 sigmoid core: accepts one operand at a time,
// bypasses saturated/NaN inputs, runs the rest through the core and emits the result.
module sigmoid_stream_driver #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MIN_WAIT       = 2,
    parameter int SAT_EXP        = 18
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [15:0] core_x,
    output logic        core_reset,
    input  logic [15:0] core_out,
    input  logic        core_finished,
    output logic        timeout_err,
    output logic [15:0] done_count
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [15:0] QNAN    = 16'h7E00;
    localparam logic [15:0] FP_ONE  = 16'h3C00;
    localparam logic [15:0] FP_ZERO = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_OUT
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [15:0]     r_core_x;
    logic [15:0]     r_out_data;
    logic            r_timeout_err;
    logic [15:0]     r_done_count;

    logic            w_accept;
    logic            w_in_nan;
    logic            w_in_sat;
    logic            w_honour;
    logic            w_timeout;
    logic            w_deliver;

    assign w_accept  = in_valid && (r_state == ST_IDLE);
    assign w_in_nan  = (in_data[14:10] == 5'd31) && (in_data[9:0] != 10'd0);
    assign w_in_sat  = (in_data[14:10] >= 5'(SAT_EXP));
    // Finished seen in the first MIN_WAIT cycles is left over from the previous op.
    assign w_honour  = (r_state == ST_WAIT) && core_finished && (r_cnt >= CW'(MIN_WAIT));
    assign w_timeout = (r_state == ST_WAIT) && !w_honour && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign w_deliver = (r_state == ST_OUT) && out_ready;

    assign in_ready    = (r_state == ST_IDLE);
    assign out_valid   = (r_state == ST_OUT);
    assign out_data    = r_out_data;
    assign core_x      = r_core_x;
    // The core is held in reset while the driver itself is in reset.
    assign core_reset  = !reset || (r_state == ST_START);
    assign timeout_err = r_timeout_err;
    assign done_count  = r_done_count;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_in_nan || w_in_sat) ? ST_OUT : ST_START;
                end
            end
            ST_START: w_state_next = ST_WAIT;
            ST_WAIT: begin
                if (w_honour || w_timeout) begin
                    w_state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_core_x      <= '0;
            r_out_data    <= '0;
            r_timeout_err <= 1'b0;
            r_done_count  <= '0;
        end else begin
            r_state <= w_state_next;

            if (w_accept) begin
                r_core_x <= in_data;
                if (w_in_nan) begin
                    r_out_data <= QNAN;
                end else if (w_in_sat) begin
                    r_out_data <= in_data[15] ? FP_ZERO : FP_ONE;
                end
            end

            if (r_state == ST_START) begin
                r_cnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_honour) begin
                r_out_data <= core_out;
            end else if (w_timeout) begin
                r_out_data    <= QNAN;
                r_timeout_err <= 1'b1;
            end

            if (w_deliver) begin
                r_done_count <= r_done_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sigmoid_stream_driver.sv
// Directed bench for sigmoid_stream_driver with a small behavioural model of the core's
// Finished timing (including a stale Finished carried over from the previous op).
module tb_sigmoid_stream_driver;

    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [15:0] core_x;
    logic        core_reset;
    logic [15:0] core_out;
    logic        core_finished;
    logic        timeout_err;
    logic [15:0] done_count;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_pulse = 0;
    int          exp_done = 0;

    // core model state
    logic [7:0]  m_cnt = 8'd0;
    int          m_delay = NEVER;
    bit          m_stale = 1'b0;
    logic [15:0] m_result = 16'h0000;

    sigmoid_stream_driver #(
        .TIMEOUT_CYCLES(64),
        .MIN_WAIT(2),
        .SAT_EXP(18)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .core_x(core_x),
        .core_reset(core_reset),
        .core_out(core_out),
        .core_finished(core_finished),
        .timeout_err(timeout_err),
        .done_count(done_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (core_reset) m_cnt <= 8'd0;
        else if (m_cnt != 8'd255) m_cnt <= m_cnt + 8'd1;
    end

    always @(posedge clk) begin
        if (reset && core_reset) n_pulse <= n_pulse + 1;
    end

    assign core_finished = (int'(m_cnt) >= m_delay) || (m_stale && (m_cnt < 8'd2));
    assign core_out      = (int'(m_cnt) >= m_delay) ? m_result : 16'hDEAD;

    // Present one operand and return at the first negedge after it was taken.
    task automatic accept(input logic [15:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count negedges (starting at 1 = first cycle after accept) until out_valid.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_done++;
    endtask

    task automatic test_reset();
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_tests++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
        n_tests++; if (core_x !== 16'h0000) begin n_fail++; $display("FAIL reset_core_x: got %h want 0000", core_x); end
        n_tests++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL reset_core_reset: got %b want 1", core_reset); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
        n_tests++; if (done_count !== 16'd0) begin n_fail++; $display("FAIL reset_done_count: got %0d want 0", done_count); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_tests++; if (core_reset !== 1'b0) begin n_fail++; $display("FAIL idle_core_reset: got %b want 0", core_reset); end
    endtask

    task automatic test_core_basic();
        int lat;
        int p0;
        m_delay = 4; m_stale = 1'b0; m_result = 16'h3800;
        p0 = n_pulse;
        @(negedge clk);
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
        accept(16'h0000);
        n_tests++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL basic_start_pulse: got %b want 1", core_reset); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b want 0", in_ready); end
        wait_out(lat);
        n_tests++; if (lat != 7) begin n_fail++; $display("FAIL basic_latency: got %0d want 7", lat); end
        n_tests++; if (out_data !== 16'h3800) begin n_fail++; $display("FAIL basic_data: got %h want 3800", out_data); end
        n_tests++; if (n_pulse - p0 != 1) begin n_fail++; $display("FAIL basic_pulses: got %0d want 1", n_pulse - p0); end
        n_tests++; if (core_x !== 16'h0000) begin n_fail++; $display("FAIL basic_core_x: got %h want 0000", core_x); end
        handshake();
        n_tests++; if (done_count !== 16'(exp_done)) begin n_fail++; $display("FAIL basic_done: got %0d want %0d", done_count, exp_done); end
        $display("[TB] txn core in=0000 out=%h lat=%0d", out_data, lat);
    endtask

    task automatic test_stale_finished();
        int lat;
        m_delay = 4; m_stale = 1'b1; m_result = 16'h344D;
        accept(16'hBC00);
        n_tests++; if (core_x !== 16'hBC00) begin n_fail++; $display("FAIL stale_core_x: got %h want BC00", core_x); end
        wait_out(lat);
        n_tests++; if (lat != 7) begin n_fail++; $display("FAIL stale_latency: got %0d want 7", lat); end
        n_tests++; if (out_data !== 16'h344D) begin n_fail++; $display("FAIL stale_data: got %h want 344D", out_data); end
        handshake();
        m_stale = 1'b0;
        n_tests++; if (done_count !== 16'(exp_done)) begin n_fail++; $display("FAIL stale_done: got %0d want %0d", done_count, exp_done); end
        $display("[TB] txn core in=BC00 out=%h lat=%0d", out_data, lat);
    endtask

    task automatic test_bypass(input logic [15:0] d, input logic [15:0] expv);
        int p0;
        p0 = n_pulse;
        m_delay = NEVER;
        accept(d);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bypass_valid %h: got %b want 1", d, out_valid); end
        n_tests++; if (out_data !== expv) begin n_fail++; $display("FAIL bypass_data %h: got %h want %h", d, out_data, expv); end
        n_tests++; if (core_reset !== 1'b0) begin n_fail++; $display("FAIL bypass_core_reset %h: got %b want 0", d, core_reset); end
        handshake();
        n_tests++; if (n_pulse != p0) begin n_fail++; $display("FAIL bypass_pulses %h: got %0d want 0", d, n_pulse - p0); end
        n_tests++; if (done_count !== 16'(exp_done)) begin n_fail++; $display("FAIL bypass_done %h: got %0d want %0d", d, done_count, exp_done); end
        $display("[TB] txn bypass in=%h out=%h", d, out_data);
    endtask

    task automatic test_timeout();
        int lat;
        m_delay = NEVER; m_stale = 1'b0;
        n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL pre_timeout_err: got %b want 0", timeout_err); end
        accept(16'h3C00);
        wait_out(lat);
        n_tests++; if (lat != 66) begin n_fail++; $display("FAIL timeout_latency: got %0d want 66", lat); end
        n_tests++; if (out_data !== 16'h7E00) begin n_fail++; $display("FAIL timeout_data: got %h want 7E00", out_data); end
        n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b want 1", timeout_err); end
        handshake();
        $display("[TB] txn timeout in=3C00 out=%h lat=%0d", out_data, lat);
        m_delay = 4; m_result = 16'h3BB0;
        accept(16'h3C00);
        wait_out(lat);
        n_tests++; if (out_data !== 16'h3BB0) begin n_fail++; $display("FAIL after_timeout_data: got %h want 3BB0", out_data); end
        n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b want 1", timeout_err); end
        handshake();
        n_tests++; if (done_count !== 16'(exp_done)) begin n_fail++; $display("FAIL timeout_done: got %0d want %0d", done_count, exp_done); end
        $display("[TB] txn core in=3C00 out=%h lat=%0d", out_data, lat);
    endtask

    task automatic test_back_to_back();
        int lat;
        m_delay = 4; m_stale = 1'b0; m_result = 16'h3800;
        accept(16'h0000);
        wait_out(lat);
        in_valid = 1'b1;
        in_data  = 16'h4C00;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_tests++; if (out_valid !== 1'b1 || out_data !== 16'h3800) begin n_fail++; $display("FAIL hold_data cyc%0d: got v=%b d=%h want v=1 d=3800", i, out_valid, out_data); end
            n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready cyc%0d: got %b want 0", i, in_ready); end
            n_tests++; if (core_x !== 16'h0000) begin n_fail++; $display("FAIL hold_core_x cyc%0d: got %h want 0000", i, core_x); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_done++;
        $display("[TB] txn core in=0000 out=3800 after backpressure");
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
        n_tests++; if (done_count !== 16'(exp_done)) begin n_fail++; $display("FAIL b2b_done1: got %0d want %0d", done_count, exp_done); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || out_data !== 16'h3C00) begin n_fail++; $display("FAIL b2b_second: got v=%b d=%h want v=1 d=3C00", out_valid, out_data); end
        n_tests++; if (done_count !== 16'(exp_done)) begin n_fail++; $display("FAIL b2b_no_dup: got %0d want %0d", done_count, exp_done); end
        handshake();
        n_tests++; if (done_count !== 16'(exp_done)) begin n_fail++; $display("FAIL b2b_done2: got %0d want %0d", done_count, exp_done); end
        $display("[TB] txn bypass in=4C00 out=3C00 back-to-back");
    endtask

    task automatic test_reset_mid_op();
        int lat;
        m_delay = NEVER; m_stale = 1'b0;
        accept(16'h0000);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        n_tests++; if (done_count !== 16'd0) begin n_fail++; $display("FAIL midrst_done: got %0d want 0", done_count); end
        n_tests++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL midrst_core_reset: got %b want 1", core_reset); end
        n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL midrst_timeout_err: got %b want 0", timeout_err); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_done = 0;
        m_delay = 4; m_result = 16'h3A00;
        accept(16'hC000);
        wait_out(lat);
        n_tests++; if (lat != 7 || out_data !== 16'h3A00) begin n_fail++; $display("FAIL postrst_op: got lat=%0d d=%h want lat=7 d=3A00", lat, out_data); end
        handshake();
        n_tests++; if (done_count !== 16'(exp_done)) begin n_fail++; $display("FAIL postrst_done: got %0d want %0d", done_count, exp_done); end
        $display("[TB] txn core in=C000 out=%h after mid-op reset", out_data);
    endtask

    initial begin
        test_reset();
        test_core_basic();
        test_stale_finished();
        test_bypass(16'h4C00, 16'h3C00);
        test_bypass(16'hCC00, 16'h0000);
        test_bypass(16'h7E01, 16'h7E00);
        test_bypass(16'hFC00, 16'h0000);
        test_timeout();
        test_back_to_back();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
